// File: rtl/messbauer_pkg.sv
// Purpose: shared state encoding, timing defaults and saw-tooth slope constants for the velocity chain.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package messbauer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_START   = 2'd1;
  localparam state_t ST_CH_HIGH = 2'd2;
  localparam state_t ST_CH_LOW  = 2'd3;

  localparam int DEF_CHANNEL_PERIOD     = 100;
  localparam int DEF_CHANNEL_HIGH_TIME  = 50;
  localparam int DEF_START_DURATION     = 10;
  localparam int DEF_CHANNELS_PER_FRAME = 4096;

  // The saw-tooth generator steps once per channel falling edge and spans
  // its full DAC range over one frame, so both blocks derive from the same
  // channel count.
  localparam int SAW_STEPS_PER_FRAME = DEF_CHANNELS_PER_FRAME;
  localparam int SAW_DAC_WIDTH       = 16;
  localparam int SAW_SLOPE           = (2 ** SAW_DAC_WIDTH) / SAW_STEPS_PER_FRAME;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/messbauer_phase_timer.sv
// Purpose: loadable phase down-counter with terminal-count flags.
// Latency: loaded value visible the cycle after load; tc_nxt predicts tc one cycle early.
// Backpressure: none; counts every cycle, holds at zero.
// Ports: clk/areset (async, active-high); load + load_val reload the counter;
//        tc = counter is zero this cycle; tc_nxt = counter will be zero next cycle.
module messbauer_phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc,
  output logic             tc_nxt
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc     = (count == '0);
  // Lets the parent register outputs that must coincide with the last cycle of a phase.
  assign tc_nxt = load ? (load_val == '0) : (count <= WIDTH'(1));

endmodule

// File: rtl/messbauer_channel_sequencer.sv
// Purpose: frame start pulse and channel advance strobe generator for the Mossbauer velocity chain.
// Latency: start rises one cycle after enable is sampled in IDLE; all outputs registered.
// Backpressure: none; free-running once started, enable only checked in IDLE and at frame end.
// Ports: clk, areset (async, active-high), enable (run request level);
//        start, channel (strobe, falling edge = advance), channel_index, frame_done (1-cycle),
//        frame_count (frames completed this run, wraps), busy (not idle).
module messbauer_channel_sequencer
  import messbauer_pkg::*;
#(
  parameter int CHANNEL_PERIOD     = DEF_CHANNEL_PERIOD,
  parameter int CHANNEL_HIGH_TIME  = DEF_CHANNEL_HIGH_TIME,
  parameter int START_DURATION     = DEF_START_DURATION,
  parameter int CHANNELS_PER_FRAME = DEF_CHANNELS_PER_FRAME,
  parameter int CHANNEL_WIDTH      = 12,
  parameter int FRAMES             = 0,
  parameter int FRAME_COUNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         enable,
  output logic                         start,
  output logic                         channel,
  output logic [CHANNEL_WIDTH-1:0]     channel_index,
  output logic                         frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         busy
);

  localparam int TW = $clog2(max_i(CHANNEL_PERIOD, START_DURATION));

  localparam logic [TW-1:0] LD_START = TW'(START_DURATION - 1);
  localparam logic [TW-1:0] LD_HIGH  = TW'(CHANNEL_HIGH_TIME - 1);
  localparam logic [TW-1:0] LD_LOW   = TW'(CHANNEL_PERIOD - CHANNEL_HIGH_TIME - 1);

  localparam logic [CHANNEL_WIDTH-1:0] LAST_CH  = CHANNEL_WIDTH'(CHANNELS_PER_FRAME - 1);
  localparam logic [31:0]              FRAMES_U = 32'(FRAMES);

  state_t state_q, state_nxt;

  logic          load;
  logic [TW-1:0] load_val;
  logic          tc, tc_nxt;

  logic armed_q, armed_d;
  logic last_ch, frame_end, cont;
  logic start_d, channel_d, busy_d, frame_done_d;
  logic [CHANNEL_WIDTH-1:0]     idx_d;
  logic [FRAME_COUNT_WIDTH-1:0] fc_d;

  messbauer_phase_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .areset   (areset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc),
    .tc_nxt   (tc_nxt)
  );

  assign last_ch   = (channel_index == LAST_CH);
  assign frame_end = (state_q == ST_CH_LOW) && tc && last_ch;
  // frame_count already holds the post-increment value during the last CH_LOW cycle.
  assign cont      = enable && ((FRAMES == 0) || (32'(frame_count) < FRAMES_U));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (enable && armed_q) state_nxt = ST_START;
      ST_START:   if (tc) state_nxt = ST_CH_HIGH;
      ST_CH_HIGH: if (tc) state_nxt = ST_CH_LOW;
      ST_CH_LOW:  if (tc) state_nxt = !last_ch ? ST_CH_HIGH : (cont ? ST_START : ST_IDLE);
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output values are decoded from the next state and registered, so every
  // output lines up exactly with the state it describes.
  always_comb begin
    load     = (state_nxt != state_q);
    load_val = '0;
    case (state_nxt)
      ST_START:   load_val = LD_START;
      ST_CH_HIGH: load_val = LD_HIGH;
      ST_CH_LOW:  load_val = LD_LOW;
      default:    load_val = '0;
    endcase

    start_d   = (state_nxt == ST_START);
    channel_d = (state_nxt == ST_CH_HIGH);
    busy_d    = (state_nxt != ST_IDLE);

    idx_d = channel_index;
    if (state_q == ST_IDLE && state_nxt == ST_START) begin
      idx_d = '0;
    end else if (state_q == ST_CH_LOW && tc) begin
      idx_d = last_ch ? '0 : channel_index + CHANNEL_WIDTH'(1);
    end

    frame_done_d = (state_nxt == ST_CH_LOW) && tc_nxt && (idx_d == LAST_CH);

    fc_d = frame_count;
    if (state_q == ST_IDLE && state_nxt == ST_START) begin
      fc_d = '0;
    end else if (frame_done_d) begin
      fc_d = frame_count + FRAME_COUNT_WIDTH'(1);
    end

    // After the frame limit stops a run, a fresh run needs enable to go low first.
    armed_d = armed_q;
    if (!enable)                armed_d = 1'b1;
    else if (frame_end && !cont) armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      start         <= 1'b0;
      channel       <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      channel_index <= '0;
      frame_count   <= '0;
      armed_q       <= 1'b1;
    end else begin
      start         <= start_d;
      channel       <= channel_d;
      busy          <= busy_d;
      frame_done    <= frame_done_d;
      channel_index <= idx_d;
      frame_count   <= fc_d;
      armed_q       <= armed_d;
    end
  end

endmodule

// File: doc/messbauer_channel_sequencer.md
Name: messbauer_channel_sequencer

Overview:
Upstream timing source for the Mössbauer velocity chain. Generates the frame "start" pulse and the "channel" advance strobe. The saw-tooth generator counts the falling edges of "channel". The block also tracks the current channel index and completed frames for the acquisition logic. It runs from the single system clock and replaces ad-hoc channel stimulus with a parameterised, frame-accurate sequence.

Parameters:
CHANNEL_PERIOD, 100, clk cycles per channel; must be >= 2.
CHANNEL_HIGH_TIME, 50, clk cycles "channel" is high in each period; range 1..CHANNEL_PERIOD-1.
START_DURATION, 10, clk cycles "start" is high at frame begin; must be >= 1.
CHANNELS_PER_FRAME, 4096, channel strobes per frame; must be >= 1.
CHANNEL_WIDTH, 12, width of channel_index; 2**CHANNEL_WIDTH >= CHANNELS_PER_FRAME.
FRAMES, 0, frames per run; 0 = run until enable drops.
FRAME_COUNT_WIDTH, 16, width of frame_count.

Ports:
clk  input  1  system clock, all logic on posedge.
areset  input  1  asynchronous, active-high reset.
enable  input  1  level run request, sampled on posedge clk.
start  output  1  frame-start pulse, registered.
channel  output  1  channel strobe, registered; falling edge = channel advance.
channel_index  output  CHANNEL_WIDTH  current channel 0..CHANNELS_PER_FRAME-1.
frame_done  output  1  one-cycle pulse at frame end.
frame_count  output  FRAME_COUNT_WIDTH  frames completed in the current run.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert): state IDLE. start, channel, frame_done, busy = 0. channel_index = 0, frame_count = 0, phase counter = 0. Takes effect immediately and aborts any frame.
- All outputs are registered and no output is combinational from enable.
- FSM states: IDLE, START, CH_HIGH, CH_LOW.
- IDLE: outputs low. When enable = 1 at a posedge:
  - go to START;
  - clear frame_count and channel_index.
  - start rises on the cycle after enable is sampled.
- START: start = 1 for exactly START_DURATION cycles. Then go to CH_HIGH with start = 0.
- CH_HIGH: channel = 1 for CHANNEL_HIGH_TIME cycles, then go to CH_LOW.
- CH_LOW: channel = 0 for CHANNEL_PERIOD - CHANNEL_HIGH_TIME cycles. At the last CH_LOW cycle:
  - channel_index < CHANNELS_PER_FRAME-1: increment channel_index (takes effect as channel rises again), go to CH_HIGH.
  - channel_index = CHANNELS_PER_FRAME-1 (frame end):
    - frame_done = 1 for one cycle; frame_count increments, wrapping modulo 2**FRAME_COUNT_WIDTH; channel_index = 0.
    - If enable = 1 and (FRAMES = 0 or new frame_count < FRAMES): go to START, with no idle gap.
    - Otherwise go to IDLE.
- Frame length: START_DURATION + CHANNELS_PER_FRAME*CHANNEL_PERIOD cycles.
- Channel edges: exactly CHANNELS_PER_FRAME falling edges of channel per frame. start and channel are never high together.
- enable drop mid-frame: the frame always completes; the block returns to IDLE at the frame boundary. enable is only evaluated in IDLE and at frame end.
- enable re-asserted in the same cycle as the frame-end decision: the continue rule above applies.
- FRAMES reached: go to IDLE even if enable = 1. A new run needs enable low then high (rising-edge re-arm held in a flag).
- Single phase down-counter is reloaded on every state entry and is wide enough for max(CHANNEL_PERIOD, START_DURATION).

Decomposition:
- Shared package messbauer_pkg holds:
  - state encoding localparams (IDLE, START, CH_HIGH, CH_LOW);
  - default timing constants CHANNEL_PERIOD, CHANNEL_HIGH_TIME, START_DURATION, CHANNELS_PER_FRAME;
  - the saw-tooth slope defaults, so both blocks agree.
- One sub-module is natural: messbauer_phase_timer. It is a loadable down-counter with a terminal-count output and is reused for the START / CH_HIGH / CH_LOW durations.

Test Plan:
- Bench parameters: CHANNEL_PERIOD=4, CHANNEL_HIGH_TIME=2, START_DURATION=3, CHANNELS_PER_FRAME=8, FRAMES=2.
- Nominal run, enable held high from cycle 0:
  - start high cycles 1-3, then 8 channel pulses (2 high, 2 low);
  - frame_done at cycle 35, second start at cycle 36;
  - IDLE after frame 2 with frame_count=2, busy=0.
- enable dropped during channel_index=3 of frame 1: all 8 channel pulses still emitted, frame_done once, IDLE, frame_count=1, no second start.
- areset pulsed mid-frame at channel_index=5: start/channel/busy go 0 and channel_index=0 without waiting for a clock edge. After release with enable=1, start rises one cycle later.
- FRAMES=0, FRAME_COUNT_WIDTH=4, enable held: continuous frames with no gap. frame_count wraps 15->0 at the 16th frame_done.
- Chain check with the saw-tooth generator on channel: exactly 8 falling edges between consecutive start pulses. start and channel are never simultaneously high; channel_index equals (falling edges seen) at each rising edge.
